// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning stage and its consumers:
// button bit positions, BCD counter width and the HOLD/RUN state encoding.
package btn_pkg;

    // Bit positions inside the 4-bit one-shot button bus.
    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;
    localparam int BTN_SEL = 2;
    localparam int BTN_RUN = 3;

    // Number of BCD digits in the counter.
    localparam int NUM_DIGITS = 4;

    // Free-running control state.
    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/btn_bcd_counter_digit.sv
// One decimal digit of the BCD counter. Purely combinational: when enabled
// the digit moves one step up or down and reports a decimal carry/borrow.
// A digit that somehow holds 10..15 is forced back into 0..9 when stepped,
// so only legal BCD values are ever produced.
module bcd_digit_step (
    input  logic [3:0] digit,
    input  logic       en,
    input  logic       down,
    output logic [3:0] next_digit,
    output logic       cout
);

    // Single-digit decimal increment/decrement with carry/borrow out.
    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (en) begin
            if (!down) begin
                if (digit >= 4'd9) begin
                    next_digit = 4'd0;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    next_digit = 4'd9;
                    cout       = 1'b1;
                end else if (digit > 4'd9) begin
                    next_digit = 4'd9;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/btn_bcd_counter.sv
// Four-digit BCD counter driven by debounced one-shot button pulses.
// Buttons step the selected digit up or down, rotate the step digit and
// toggle a free-running mode that auto-increments every RUN_DIV cycles.
// Everything lives in the cclk domain; all outputs come straight from flops.
module btn_bcd_counter
    import btn_pkg::*;
#(
    parameter int RUN_DIV = 190
) (
    input  logic        cclk,
    input  logic        clr,
    input  logic [3:0]  btn,
    output logic [15:0] bcd,
    output logic [1:0]  digit_sel,
    output logic        running,
    output logic        wrap
);

    // Terminal value of the tick divider.
    localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

    run_state_t  state_reg;
    logic [15:0] div_reg;
    logic [15:0] div_next;
    logic [15:0] bcd_reg;
    logic [15:0] bcd_next;
    logic [1:0]  sel_reg;
    logic [1:0]  sel_next;
    logic        running_reg;
    logic        wrap_reg;
    logic        wrap_next;

    logic inc_req;
    logic dec_req;
    logic terminal;
    logic leaving_run;
    logic tick_step;
    logic step_en;
    logic step_down;

    // Request decode. Inc and dec together cancel each other. Any button
    // step, or a toggle back into HOLD, swallows a coinciding divider tick;
    // the divider itself still returns to zero on its terminal count.
    always_comb begin
        inc_req     = btn[BTN_INC] & ~btn[BTN_DEC];
        dec_req     = btn[BTN_DEC] & ~btn[BTN_INC];
        terminal    = (state_reg == RUN) && (div_reg == DIV_LAST);
        leaving_run = (state_reg == RUN) && btn[BTN_RUN];
        tick_step   = terminal && !leaving_run && !btn[BTN_INC] && !btn[BTN_DEC];
        step_en     = inc_req | dec_req | tick_step;
        step_down   = dec_req;
    end

    // Digit chain: the selected digit steps on request, each higher digit
    // steps only when the digit below carries or borrows out. Digits below
    // the selected one never see an enable and keep their value.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic       carry_in;
            logic       en;
            logic       cout;
            logic [3:0] nxt;

            if (gi == 0) begin : g_first
                assign carry_in = 1'b0;
            end else begin : g_chain
                assign carry_in = g_digit[gi-1].cout;
            end

            assign en = (step_en && (sel_reg == 2'(gi))) || carry_in;

            bcd_digit_step u_step (
                .digit      (bcd_reg[4*gi +: 4]),
                .en         (en),
                .down       (step_down),
                .next_digit (nxt),
                .cout       (cout)
            );

            assign bcd_next[4*gi +: 4] = nxt;
        end
    endgenerate

    // Wrap, step-digit rotation and divider next-state.
    always_comb begin
        wrap_next = step_en && g_digit[NUM_DIGITS-1].cout;
        sel_next  = btn[BTN_SEL] ? sel_reg + 2'd1 : sel_reg;
        if ((state_reg == RUN) && !btn[BTN_RUN] && !terminal) begin
            div_next = div_reg + 16'd1;
        end else begin
            div_next = 16'd0;
        end
    end

    // HOLD/RUN state machine together with counter and output registers.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            state_reg   <= HOLD;
            div_reg     <= 16'd0;
            bcd_reg     <= 16'h0000;
            sel_reg     <= 2'd0;
            running_reg <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (btn[BTN_RUN]) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (btn[BTN_RUN]) begin
                        state_reg   <= HOLD;
                        running_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= HOLD;
                    running_reg <= 1'b0;
                end
            endcase
            div_reg  <= div_next;
            bcd_reg  <= bcd_next;
            sel_reg  <= sel_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bcd       = bcd_reg;
    assign digit_sel = sel_reg;
    assign running   = running_reg;
    assign wrap      = wrap_reg;

endmodule

// File: tb/tb_btn_bcd_counter.sv
// Self-checking bench for btn_bcd_counter with RUN_DIV = 4. A table of
// per-cycle button vectors and hand-derived expected outputs is pushed into
// a scoreboard as each vector is driven and popped after the sampling edge.
// Hand-written sequences cover asynchronous clear and the RUN latency.
module tb_btn_bcd_counter;

    localparam int DIV = 4;

    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_INC  = 4'b0001;
    localparam logic [3:0] B_DEC  = 4'b0010;
    localparam logic [3:0] B_SEL  = 4'b0100;
    localparam logic [3:0] B_RUN  = 4'b1000;

    typedef struct packed {
        logic        rst;
        logic [3:0]  b;
        logic [15:0] bcd;
        logic [1:0]  sel;
        logic        run;
        logic        wrap;
    } vec_t;

    logic        cclk;
    logic        clr;
    logic [3:0]  btn;
    logic [15:0] bcd;
    logic [1:0]  digit_sel;
    logic        running;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t sb[$];

    btn_bcd_counter #(.RUN_DIV(DIV)) dut (
        .cclk      (cclk),
        .clr       (clr),
        .btn       (btn),
        .bcd       (bcd),
        .digit_sel (digit_sel),
        .running   (running),
        .wrap      (wrap)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] b, input logic [15:0] v,
                       input logic [1:0] s, input logic run, input logic w);
        vec_t e;
        e.rst  = r;
        e.b    = b;
        e.bcd  = v;
        e.sel  = s;
        e.run  = run;
        e.wrap = w;
        vecs.push_back(e);
    endtask

    // Drive one vector for one cycle, then compare against the scoreboard.
    task automatic apply_row(input int idx);
        vec_t v;
        vec_t e;
        v = vecs[idx];
        @(negedge cclk);
        clr = v.rst;
        btn = v.b;
        sb.push_back(v);
        @(posedge cclk);
        #1;
        btn = B_NONE;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard row %0d: queue empty, expected one entry", idx);
        end else begin
            e = sb.pop_front();
            $display("row %0d clr=%b btn=%b -> bcd=%h sel=%0d run=%b wrap=%b", idx, v.rst, v.b,
                     bcd, digit_sel, running, wrap);
            chk($sformatf("bcd[%0d]", idx), bcd, e.bcd);
            chk($sformatf("digit_sel[%0d]", idx), {14'd0, digit_sel}, {14'd0, e.sel});
            chk($sformatf("running[%0d]", idx), {15'd0, running}, {15'd0, e.run});
            chk($sformatf("wrap[%0d]", idx), {15'd0, wrap}, {15'd0, e.wrap});
        end
    endtask

    initial begin
        int first_change;
        clr = 1'b1;
        btn = B_NONE;

        // Build 0123 in RUN (rows 0..8).
        add(0, B_INC, 16'h0001, 2'd0, 0, 0);
        add(0, B_INC, 16'h0002, 2'd0, 0, 0);
        add(0, B_INC, 16'h0003, 2'd0, 0, 0);
        add(0, B_SEL, 16'h0003, 2'd1, 0, 0);
        add(0, B_INC, 16'h0013, 2'd1, 0, 0);
        add(0, B_INC, 16'h0023, 2'd1, 0, 0);
        add(0, B_SEL, 16'h0023, 2'd2, 0, 0);
        add(0, B_INC, 16'h0123, 2'd2, 0, 0);
        add(0, B_RUN, 16'h0123, 2'd2, 1, 0);
        // After async clear: back-to-back increments.
        add(0, B_INC, 16'h0001, 2'd0, 0, 0);
        add(0, B_INC, 16'h0002, 2'd0, 0, 0);
        add(0, B_INC, 16'h0003, 2'd0, 0, 0);
        // Select together with increment uses the old step.
        add(0, B_INC | B_SEL, 16'h0004, 2'd1, 0, 0);
        for (int k = 1; k <= 9; k++) add(0, B_INC, 16'h0004 + 16'(k) * 16'h0010, 2'd1, 0, 0);
        add(0, B_SEL, 16'h0094, 2'd2, 0, 0);
        add(0, B_SEL, 16'h0094, 2'd3, 0, 0);
        add(0, B_SEL, 16'h0094, 2'd0, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, B_INC, 16'h0094 + 16'(k), 2'd0, 0, 0);
        add(0, B_INC, 16'h0100, 2'd0, 0, 0);
        add(0, B_DEC, 16'h0099, 2'd0, 0, 0);
        // Borrow wrap on the tens digit: 0005 - 10 -> 9995.
        add(1, B_NONE, 16'h0000, 2'd0, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, B_INC, 16'(k), 2'd0, 0, 0);
        add(0, B_SEL, 16'h0005, 2'd1, 0, 0);
        add(0, B_DEC, 16'h9995, 2'd1, 0, 1);
        add(0, B_NONE, 16'h9995, 2'd1, 0, 0);
        add(0, B_SEL, 16'h9995, 2'd2, 0, 0);
        add(0, B_SEL, 16'h9995, 2'd3, 0, 0);
        add(0, B_SEL, 16'h9995, 2'd0, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, B_INC, 16'h9995 + 16'(k), 2'd0, 0, 0);
        add(0, B_INC | B_DEC, 16'h9999, 2'd0, 0, 0);
        add(0, B_INC, 16'h0000, 2'd0, 0, 1);
        add(0, B_NONE, 16'h0000, 2'd0, 0, 0);
        // Step select to hundreds and back around.
        add(1, B_NONE, 16'h0000, 2'd0, 0, 0);
        add(0, B_SEL, 16'h0000, 2'd1, 0, 0);
        add(0, B_SEL, 16'h0000, 2'd2, 0, 0);
        add(0, B_INC, 16'h0100, 2'd2, 0, 0);
        add(0, B_SEL, 16'h0100, 2'd3, 0, 0);
        add(0, B_SEL, 16'h0100, 2'd0, 0, 0);
        // RUN cadence: increments 4, 8 and 12 edges after the toggle.
        add(1, B_NONE, 16'h0000, 2'd0, 0, 0);
        add(0, B_RUN, 16'h0000, 2'd0, 1, 0);
        for (int n = 1; n <= 12; n++) add(0, B_NONE, 16'(n / 4), 2'd0, 1, 0);
        add(0, B_RUN, 16'h0003, 2'd0, 0, 0);
        for (int n = 0; n < 5; n++) add(0, B_NONE, 16'h0003, 2'd0, 0, 0);
        // Increment on the terminal tick: one step only, cadence restarts.
        add(0, B_RUN, 16'h0003, 2'd0, 1, 0);
        for (int n = 0; n < 3; n++) add(0, B_NONE, 16'h0003, 2'd0, 1, 0);
        add(0, B_INC, 16'h0004, 2'd0, 1, 0);
        for (int n = 0; n < 3; n++) add(0, B_NONE, 16'h0004, 2'd0, 1, 0);
        add(0, B_NONE, 16'h0005, 2'd0, 1, 0);
        add(0, B_RUN, 16'h0005, 2'd0, 0, 0);
        // Toggle into HOLD on the terminal tick suppresses it.
        add(0, B_RUN, 16'h0005, 2'd0, 1, 0);
        for (int n = 0; n < 3; n++) add(0, B_NONE, 16'h0005, 2'd0, 1, 0);
        add(0, B_RUN, 16'h0005, 2'd0, 0, 0);
        for (int n = 0; n < 4; n++) add(0, B_NONE, 16'h0005, 2'd0, 0, 0);
        // Toggle together with increment: both applied.
        add(0, B_RUN | B_INC, 16'h0006, 2'd0, 1, 0);
        add(0, B_RUN, 16'h0006, 2'd0, 0, 0);

        // Reset state.
        repeat (2) @(posedge cclk);
        #1;
        chk("reset bcd", bcd, 16'h0000);
        chk("reset digit_sel", {14'd0, digit_sel}, 16'd0);
        chk("reset running", {15'd0, running}, 16'd0);
        chk("reset wrap", {15'd0, wrap}, 16'd0);
        @(negedge cclk);
        clr = 1'b0;

        for (int i = 0; i < 9; i++) apply_row(i);

        // Asynchronous clear mid-cycle, well away from any clock edge.
        #2;
        clr = 1'b1;
        #1;
        $display("async clr -> bcd=%h sel=%0d run=%b wrap=%b", bcd, digit_sel, running, wrap);
        chk("async clr bcd", bcd, 16'h0000);
        chk("async clr digit_sel", {14'd0, digit_sel}, 16'd0);
        chk("async clr running", {15'd0, running}, 16'd0);
        chk("async clr wrap", {15'd0, wrap}, 16'd0);

        for (int i = 9; i < vecs.size(); i++) apply_row(i);

        // First auto-increment latency measured with a bounded wait.
        @(negedge cclk);
        btn = B_RUN;
        @(posedge cclk);
        #1;
        btn = B_NONE;
        chk("latency running", {15'd0, running}, 16'd1);
        first_change = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge cclk);
            #1;
            if (bcd != 16'h0006) begin
                first_change = c;
                break;
            end
        end
        $display("run latency -> first change after %0d edges, bcd=%h", first_change, bcd);
        if (first_change == 0) begin
            checks++;
            errors++;
            $display("FAIL run latency: no increment within 20 edges, expected one after %0d", DIV);
        end else begin
            chk("run latency edges", 16'(first_change), 16'(DIV));
            chk("run latency bcd", bcd, 16'h0007);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
